// File: rtl/axi4_full_rd2umi_pkg.sv
// Shared UMI command layout, AXI codes and FSM encoding for the AXI4 read to UMI bridge.
package axi4_full_rd2umi_pkg;

    localparam logic [4:0] UMI_REQ_READ  = 5'h01;
    localparam logic [4:0] UMI_RESP_READ = 5'h02;

    localparam int UMI_OPCODE_MSB = 4;
    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_SIZE_MSB   = 7;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_LEN_MSB    = 15;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_QOS_MSB    = 19;
    localparam int UMI_QOS_LSB    = 16;
    localparam int UMI_PROT_MSB   = 21;
    localparam int UMI_PROT_LSB   = 20;
    localparam int UMI_EOM_BIT    = 22;
    localparam int UMI_ERR_MSB    = 26;
    localparam int UMI_ERR_LSB    = 25;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_UMI_READ  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_SEND_R    = 2'd3;

    // Oversized AXI beats are a protocol violation; shrink them to the bus width.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_log2);
        return (size > max_log2) ? max_log2 : size;
    endfunction

endpackage

// File: rtl/axi4_full_rd2umi_umi_pack.sv
// Assembles a UMI request command word; fields not driven here are zero.
module axi4_full_rd2umi_umi_pack
    import axi4_full_rd2umi_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [4:0]    i_opcode,
    input  logic [2:0]    i_size,
    input  logic [7:0]    i_len,
    input  logic [3:0]    i_qos,
    input  logic [1:0]    i_prot,
    input  logic          i_eom,
    output logic [CW-1:0] o_cmd
);

    always_comb begin
        o_cmd = '0;
        o_cmd[UMI_OPCODE_MSB:UMI_OPCODE_LSB] = i_opcode;
        o_cmd[UMI_SIZE_MSB:UMI_SIZE_LSB]     = i_size;
        o_cmd[UMI_LEN_MSB:UMI_LEN_LSB]       = i_len;
        o_cmd[UMI_QOS_MSB:UMI_QOS_LSB]       = i_qos;
        o_cmd[UMI_PROT_MSB:UMI_PROT_LSB]     = i_prot;
        o_cmd[UMI_EOM_BIT]                   = i_eom;
    end

endmodule

// File: rtl/axi4_full_rd2umi.sv
// AXI4 read slave to UMI host bridge: one UMI REQ_READ per AXI beat, one
// outstanding transaction, responses returned in order as R beats.
module axi4_full_rd2umi
    import axi4_full_rd2umi_pkg::*;
#(
    parameter int             CW       = 32,
    parameter int             DW       = 128,
    parameter int             AW       = 64,
    parameter int             IDW      = 8,
    parameter logic [AW-1:0]  HOSTADDR = '0,
    parameter int             STRBW    = DW/8
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [IDW-1:0] s_axi_arid,
    input  logic [AW-1:0]  s_axi_araddr,
    input  logic [7:0]     s_axi_arlen,
    input  logic [2:0]     s_axi_arsize,
    input  logic [1:0]     s_axi_arburst,
    input  logic           s_axi_arlock,
    input  logic [3:0]     s_axi_arcache,
    input  logic [2:0]     s_axi_arprot,
    input  logic [3:0]     s_axi_arqos,
    input  logic           s_axi_arvalid,
    output logic           s_axi_arready,
    output logic [IDW-1:0] s_axi_rid,
    output logic [DW-1:0]  s_axi_rdata,
    output logic [1:0]     s_axi_rresp,
    output logic           s_axi_rlast,
    output logic           s_axi_rvalid,
    input  logic           s_axi_rready,
    output logic           uhost_req_valid,
    output logic [CW-1:0]  uhost_req_cmd,
    output logic [AW-1:0]  uhost_req_dstaddr,
    output logic [AW-1:0]  uhost_req_srcaddr,
    output logic [DW-1:0]  uhost_req_data,
    input  logic           uhost_req_ready,
    input  logic           uhost_resp_valid,
    input  logic [CW-1:0]  uhost_resp_cmd,
    input  logic [AW-1:0]  uhost_resp_dstaddr,
    input  logic [AW-1:0]  uhost_resp_srcaddr,
    input  logic [DW-1:0]  uhost_resp_data,
    output logic           uhost_resp_ready
);

    localparam int STRB_LOG2 = $clog2(STRBW);

    if (DW > 128) begin : g_dw_check
        $error("axi4_full_rd2umi: DW must not exceed 128");
    end

    logic [1:0]     r_state;
    logic [IDW-1:0] r_id;
    logic [AW-1:0]  r_addr;
    logic [2:0]     r_size;
    logic [1:0]     r_burst;
    logic [1:0]     r_prot;
    logic [3:0]     r_qos;
    logic [8:0]     r_beats_left;
    logic [7:0]     r_lane;
    logic [DW-1:0]  r_rdata;
    logic [1:0]     r_rresp;

    logic       w_ar_fire;
    logic       w_req_fire;
    logic       w_resp_fire;
    logic       w_r_fire;
    logic       w_last;
    logic [7:0] w_nb;
    logic [7:0] w_off;
    logic [7:0] w_len;
    logic [7:0] w_lane;
    logic       w_unused;

    assign s_axi_arready    = (r_state == ST_IDLE);
    assign uhost_req_valid  = (r_state == ST_UMI_READ);
    assign uhost_resp_ready = (r_state == ST_WAIT_RESP);
    assign s_axi_rvalid     = (r_state == ST_SEND_R);

    assign w_ar_fire   = s_axi_arvalid & s_axi_arready;
    assign w_req_fire  = uhost_req_valid & uhost_req_ready;
    assign w_resp_fire = uhost_resp_valid & uhost_resp_ready;
    assign w_r_fire    = s_axi_rvalid & s_axi_rready;
    assign w_last      = (r_beats_left == 9'd0);

    // An unaligned first beat only reads up to the next beat-size boundary.
    assign w_nb   = 8'd1 << r_size;
    assign w_off  = r_addr[7:0] & (w_nb - 8'd1);
    assign w_len  = w_nb - w_off - 8'd1;
    assign w_lane = r_addr[7:0] & 8'(STRBW - 1);

    assign uhost_req_dstaddr = r_addr;
    assign uhost_req_srcaddr = HOSTADDR;
    assign uhost_req_data    = '0;
    assign s_axi_rid         = r_id;
    assign s_axi_rdata       = r_rdata;
    assign s_axi_rresp       = r_rresp;
    assign s_axi_rlast       = w_last;

    assign w_unused = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot[2], uhost_resp_cmd,
                        uhost_resp_dstaddr, uhost_resp_srcaddr};

    axi4_full_rd2umi_umi_pack #(.CW(CW)) u_pack (
        .i_opcode (UMI_REQ_READ),
        .i_size   (3'd0),
        .i_len    (w_len),
        .i_qos    (r_qos),
        .i_prot   (r_prot),
        .i_eom    (w_last),
        .o_cmd    (uhost_req_cmd)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (w_ar_fire)   r_state <= ST_UMI_READ;
                ST_UMI_READ:  if (w_req_fire)  r_state <= ST_WAIT_RESP;
                ST_WAIT_RESP: if (w_resp_fire) r_state <= ST_SEND_R;
                ST_SEND_R:    if (w_r_fire)    r_state <= w_last ? ST_IDLE : ST_UMI_READ;
                default:                       r_state <= ST_IDLE;
            endcase
        end
    end

    // Lane is sampled before the address advances so the response lands in this beat's lanes.
    always_ff @(posedge clk) begin
        if (w_ar_fire) begin
            r_id         <= s_axi_arid;
            r_addr       <= s_axi_araddr;
            r_size       <= clamp_size(s_axi_arsize, 3'(STRB_LOG2));
            r_burst      <= s_axi_arburst;
            r_prot       <= s_axi_arprot[1:0];
            r_qos        <= s_axi_arqos;
            r_beats_left <= {1'b0, s_axi_arlen};
        end
        if (w_req_fire) begin
            r_lane <= w_lane;
            if (r_burst == AXI_BURST_INCR) begin
                r_addr <= (r_addr & ~{{(AW-8){1'b0}}, w_nb - 8'd1}) + {{(AW-8){1'b0}}, w_nb};
            end
        end
        if (w_resp_fire) begin
            r_rdata <= uhost_resp_data << {r_lane, 3'b000};
            r_rresp <= (uhost_resp_cmd[UMI_OPCODE_MSB:UMI_OPCODE_LSB] != UMI_RESP_READ)
                       ? AXI_RESP_SLVERR : uhost_resp_cmd[UMI_ERR_MSB:UMI_ERR_LSB];
        end
        if (w_r_fire) begin
            r_beats_left <= r_beats_left - 9'd1;
        end
    end

endmodule

// File: tb/tb_axi4_full_rd2umi.sv
// Directed bench for axi4_full_rd2umi: byte-memory responder, per-beat reference model
// and a negedge monitor comparing every request and R beat.
module tb_axi4_full_rd2umi;

    localparam int CW = 32;
    localparam int DW = 128;
    localparam int AW = 64;
    localparam int IDW = 8;
    localparam logic [63:0] HOST = 64'h0000_0000_CAFE_0000;

    logic           clk = 0;
    logic           nreset;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arlock;
    logic [3:0]     arcache;
    logic [2:0]     arprot;
    logic [3:0]     arqos;
    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;
    logic           req_valid;
    logic [CW-1:0]  req_cmd;
    logic [AW-1:0]  req_dst;
    logic [AW-1:0]  req_src;
    logic [DW-1:0]  req_data;
    logic           req_ready;
    logic           resp_valid;
    logic [CW-1:0]  resp_cmd;
    logic [AW-1:0]  resp_dst;
    logic [AW-1:0]  resp_src;
    logic [DW-1:0]  resp_data;
    logic           resp_ready;

    axi4_full_rd2umi #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW), .HOSTADDR(HOST)) dut (
        .clk(clk), .nreset(nreset),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .uhost_req_valid(req_valid), .uhost_req_cmd(req_cmd), .uhost_req_dstaddr(req_dst),
        .uhost_req_srcaddr(req_src), .uhost_req_data(req_data), .uhost_req_ready(req_ready),
        .uhost_resp_valid(resp_valid), .uhost_resp_cmd(resp_cmd), .uhost_resp_dstaddr(resp_dst),
        .uhost_resp_srcaddr(resp_src), .uhost_resp_data(resp_data), .uhost_resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] dst; logic [7:0] len; logic eom; logic [1:0] prot; logic [3:0] qos;} req_t;
    typedef struct {logic [127:0] data; logic [1:0] resp; logic last; logic [7:0] id;} rbeat_t;
    typedef struct {logic [63:0] dst; logic [7:0] len;} pend_t;
    typedef struct {logic [4:0] op; logic [1:0] err;} rsp_t;

    req_t   exp_req[$];
    rbeat_t exp_r[$];
    pend_t  pend[$];
    rsp_t   rsp_plan[$];
    logic [4:0] plan_op [256];
    logic [1:0] plan_err [256];

    logic [63:0]  obs_dst[$];
    logic [7:0]   obs_len[$];
    logic         obs_eom[$];
    logic [127:0] obs_rdata[$];
    logic [1:0]   obs_rresp[$];
    logic         obs_rlast[$];

    int total = 0;
    int bad = 0;
    int resp_delay = 2;
    logic kill = 0;
    logic lat_ar = 0;
    logic lat_resp = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic reset_plan();
        for (int i = 0; i < 256; i++) begin
            plan_op[i] = 5'h02;
            plan_err[i] = 2'b00;
        end
    endtask

    task automatic clear_obs();
        obs_dst.delete(); obs_len.delete(); obs_eom.delete();
        obs_rdata.delete(); obs_rresp.delete(); obs_rlast.delete();
    endtask

    // Expected UMI requests and R beats for one AXI read, from the byte-level view of the burst.
    task automatic model_ar(input logic [7:0] id, input logic [63:0] addr, input int len,
                            input int size, input logic [1:0] burst, input logic [1:0] prot,
                            input logic [3:0] qos);
        int nb;
        logic [63:0] a;
        nb = 1 << ((size > 4) ? 4 : size);
        a = addr;
        for (int b = 0; b <= len; b++) begin
            int off, rl, lane;
            req_t q;
            rbeat_t r;
            rsp_t p;
            off  = int'(a & 64'(nb - 1));
            rl   = nb - off - 1;
            lane = int'(a & 64'hF);
            q.dst = a; q.len = 8'(rl); q.eom = (b == len); q.prot = prot; q.qos = qos;
            exp_req.push_back(q);
            r.data = '0;
            for (int i = 0; i <= rl; i++) r.data[8*(lane+i) +: 8] = mem_byte(a + 64'(i));
            p.op = plan_op[b]; p.err = plan_err[b];
            rsp_plan.push_back(p);
            r.resp = (p.op != 5'h02) ? 2'b10 : p.err;
            r.last = (b == len);
            r.id = id;
            exp_r.push_back(r);
            if (burst == 2'b01) a = a - 64'(off) + 64'(nb);
        end
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [63:0] addr, input int len,
                         input int size, input logic [1:0] burst, input logic [2:0] prot,
                         input logic [3:0] qos);
        bit ok;
        model_ar(id, addr, len, size, burst, prot[1:0], qos);
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst;
        arprot = prot; arqos = qos; arvalid = 1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) chk("ar_accept_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_r.size() == 0 && exp_req.size() == 0) break;
        end
        chk("drain_r_left", exp_r.size(), 0);
        @(negedge clk);
        chk("idle_arready", arready, 1);
    endtask

    initial begin : req_ready_gen
        int c;
        c = 0;
        req_ready = 1;
        forever begin
            @(posedge clk); #1;
            req_ready = (c % 3 != 2);
            c++;
        end
    end

    initial begin : responder
        pend_t p;
        rsp_t rp;
        bit dropped;
        bit got;
        resp_valid = 0; resp_cmd = '0; resp_data = '0; resp_dst = '0; resp_src = '0;
        forever begin
            @(posedge clk);
            if (kill) begin
                pend.delete(); rsp_plan.delete(); kill = 0;
                continue;
            end
            if (pend.size() == 0) continue;
            p = pend.pop_front();
            if (rsp_plan.size() > 0) rp = rsp_plan.pop_front();
            else begin rp.op = 5'h02; rp.err = 2'b00; end
            dropped = 0;
            for (int d = 0; d < resp_delay; d++) begin
                @(posedge clk);
                if (kill) begin dropped = 1; break; end
            end
            if (dropped) continue;
            #1;
            resp_cmd = '0;
            resp_cmd[4:0] = rp.op;
            resp_cmd[15:8] = p.len;
            resp_cmd[26:25] = rp.err;
            resp_data = '0;
            for (int i = 0; i <= int'(p.len); i++) resp_data[8*i +: 8] = mem_byte(p.dst + 64'(i));
            resp_dst = 64'hDEAD_BEEF_0000_0000 ^ p.dst;
            resp_src = 64'h1234;
            resp_valid = 1;
            got = 0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (resp_ready) begin got = 1; break; end
            end
            if (!got) chk("resp_accept_timeout", 0, 1);
            @(posedge clk); #1;
            resp_valid = 0;
        end
    end

    initial begin : monitor
        req_t e;
        rbeat_t r;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                lat_ar = 0; lat_resp = 0;
                continue;
            end
            if (lat_ar) begin chk("ar_to_req_latency", req_valid, 1); lat_ar = 0; end
            if (lat_resp) begin chk("resp_to_r_latency", rvalid, 1); lat_resp = 0; end
            if (arvalid && arready) lat_ar = 1;
            if (resp_valid && resp_ready) lat_resp = 1;
            if (req_valid) chk("req_while_rvalid", rvalid, 0);
            if (req_valid && req_ready) begin
                if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
                else begin
                    e = exp_req.pop_front();
                    chk("req_dst", req_dst, e.dst);
                    chk("req_src", req_src, HOST);
                    chk("req_data", req_data, 0);
                    chk("req_opcode", req_cmd[4:0], 5'h01);
                    chk("req_size", req_cmd[7:5], 0);
                    chk("req_len", req_cmd[15:8], e.len);
                    chk("req_qos", req_cmd[19:16], e.qos);
                    chk("req_prot", req_cmd[21:20], e.prot);
                    chk("req_eom", req_cmd[22], e.eom);
                    chk("req_other_fields", req_cmd[31:23], 0);
                end
                pend.push_back('{dst: req_dst, len: req_cmd[15:8]});
                obs_dst.push_back(req_dst);
                obs_len.push_back(req_cmd[15:8]);
                obs_eom.push_back(req_cmd[22]);
            end
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    r = exp_r[0];
                    chk("r_data", rdata, r.data);
                    chk("r_resp", rresp, r.resp);
                    chk("r_last", rlast, r.last);
                    chk("r_id", rid, r.id);
                    if (rready) begin
                        void'(exp_r.pop_front());
                        obs_rdata.push_back(rdata);
                        obs_rresp.push_back(rresp);
                        obs_rlast.push_back(rlast);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        nreset = 0; arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = 0; arcache = '0; arprot = '0; arqos = '0; rready = 1;
        reset_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_resp_ready", resp_ready, 0);
        @(posedge clk); #1;
        nreset = 1;

        // Single aligned 16-byte beat
        clear_obs();
        do_ar(8'h11, 64'h100, 0, 4, 2'b01, 3'b011, 4'h5);
        wait_done();
        chk("t1_dst", obs_dst[0], 64'h100);
        chk("t1_len", obs_len[0], 15);
        chk("t1_eom", obs_eom[0], 1);
        chk("t1_rlast", obs_rlast[0], 1);
        chk("t1_rresp", obs_rresp[0], 0);

        // INCR word burst
        clear_obs();
        do_ar(8'h22, 64'h1000, 3, 2, 2'b01, 3'b000, 4'h0);
        wait_done();
        chk("t2_dst0", obs_dst[0], 64'h1000);
        chk("t2_dst1", obs_dst[1], 64'h1004);
        chk("t2_dst2", obs_dst[2], 64'h1008);
        chk("t2_dst3", obs_dst[3], 64'h100C);
        chk("t2_len2", obs_len[2], 3);
        chk("t2_rlast", {obs_rlast[0], obs_rlast[1], obs_rlast[2], obs_rlast[3]}, 4'b0001);
        chk("t2_lane1_only", obs_rdata[1] & ~(128'hFFFF_FFFF << 32), 0);

        // FIXED burst
        clear_obs();
        do_ar(8'h33, 64'h20, 2, 3, 2'b00, 3'b010, 4'hA);
        wait_done();
        chk("t3_dst1", obs_dst[1], 64'h20);
        chk("t3_dst2", obs_dst[2], 64'h20);
        chk("t3_eom", {obs_eom[0], obs_eom[1], obs_eom[2]}, 3'b001);

        // Unaligned start
        clear_obs();
        do_ar(8'h44, 64'h103, 1, 2, 2'b01, 3'b001, 4'h3);
        wait_done();
        chk("t4_dst0", obs_dst[0], 64'h103);
        chk("t4_len0", obs_len[0], 0);
        chk("t4_dst1", obs_dst[1], 64'h104);
        chk("t4_len1", obs_len[1], 3);
        chk("t4_lane3", obs_rdata[0], {120'd0, mem_byte(64'h103)} << 24);

        // Per-beat error responses
        clear_obs();
        plan_op[0] = 5'h02; plan_err[0] = 2'b01;
        plan_op[1] = 5'h04; plan_err[1] = 2'b00;
        plan_op[2] = 5'h02; plan_err[2] = 2'b00;
        do_ar(8'h55, 64'h200, 2, 4, 2'b01, 3'b000, 4'h0);
        wait_done();
        reset_plan();
        chk("t5_rresp0", obs_rresp[0], 2'b01);
        chk("t5_rresp1", obs_rresp[1], 2'b10);
        chk("t5_rresp2", obs_rresp[2], 2'b00);

        // WRAP behaves as FIXED; oversized arsize clamps to the bus width
        clear_obs();
        do_ar(8'h5A, 64'h300, 1, 7, 2'b10, 3'b000, 4'h0);
        wait_done();
        chk("wrap_dst1", obs_dst[1], 64'h300);
        chk("clamp_len", obs_len[1], 15);

        // 256-beat byte burst exercises the full beat counter
        clear_obs();
        do_ar(8'h99, 64'h4000, 255, 0, 2'b01, 3'b000, 4'h0);
        wait_done();
        chk("long_beats", obs_rlast.size(), 256);
        chk("long_last_dst", obs_dst[255], 64'h40FF);
        chk("long_rlast_first", obs_rlast[0], 0);

        // R backpressure
        clear_obs();
        rready = 0;
        fork
            do_ar(8'h66, 64'h500, 1, 4, 2'b01, 3'b000, 4'h0);
        join_none
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rvalid) begin seen = 1; break; end
        end
        chk("t6_rvalid_seen", seen, 1);
        repeat (5) @(posedge clk);
        #1 rready = 1;
        wait_done();
        chk("t6_beats", obs_rlast.size(), 2);

        // Reset while waiting for a UMI response
        clear_obs();
        resp_delay = 20;
        do_ar(8'h77, 64'h600, 3, 4, 2'b01, 3'b000, 4'h0);
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (obs_dst.size() > 0) begin seen = 1; break; end
        end
        chk("t6_req_seen", seen, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_wait_resp_ready", resp_ready, 1);
        #1 nreset = 0;
        @(posedge clk); #1;
        chk("t6_rst_arready", arready, 1);
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_req_valid", req_valid, 0);
        chk("t6_rst_resp_ready", resp_ready, 0);
        exp_req.delete(); exp_r.delete();
        kill = 1;
        @(posedge clk); #1;
        nreset = 1;
        resp_delay = 2;
        repeat (4) @(posedge clk);

        // Recovery after reset
        clear_obs();
        do_ar(8'h88, 64'h700, 0, 4, 2'b01, 3'b000, 4'h0);
        wait_done();
        chk("t7_dst", obs_dst[0], 64'h700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
